// File: rtl/ray_pkg.sv
// Shared ray-pipeline types: Q16.16 distance type, constants and the
// closest-hit collector state encoding.
package ray_pkg;

  typedef logic signed [31:0] fip_t;

  localparam fip_t FIP_ONE = 32'sh00010000;
  localparam fip_t T_INIT  = 32'sh7FFFFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/closest_hit_if.sv
// Ray start, intersection result stream and summary handshake for closest_hit.
// The slave modport is the collector's view; master is the surrounding driver.
interface closest_hit_if #(parameter int IDX_W = 16);
  import ray_pkg::*;

  logic             i_start;
  logic [IDX_W-1:0] i_num_tri;
  logic             o_start_ready;
  logic             i_valid;
  fip_t             i_t;
  logic             i_result;
  logic             o_valid;
  logic             i_ready;
  logic             o_hit;
  fip_t             o_t;
  logic [IDX_W-1:0] o_tri_idx;
  logic             o_err;

  modport slave (
    input  i_start, i_num_tri, i_valid, i_t, i_result, i_ready,
    output o_start_ready, o_valid, o_hit, o_t, o_tri_idx, o_err
  );

  modport master (
    output i_start, i_num_tri, i_valid, i_t, i_result, i_ready,
    input  o_start_ready, o_valid, o_hit, o_t, o_tri_idx, o_err
  );
endinterface

// File: rtl/closest_hit.sv
// Collects N in-order (t, hit) results per ray, keeps the nearest hit and its
// arrival index, and hands one summary per ray to the shading stage.
module closest_hit #(
  parameter int                 IDX_W  = 16,
  parameter logic signed [31:0] T_INIT = 32'sh7FFFFFFF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  closest_hit_if.slave  bus
);
  import ray_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  fip_t             best_t_q, best_t_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic             start_rdy, start_acc;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_t_q   <= T_INIT;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_t_q   <= best_t_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
    end
  end

  // DONE frees the start port in the same cycle the summary is taken
  assign start_rdy = (state_q == IDLE) || ((state_q == DONE) && bus.i_ready);
  assign start_acc = bus.i_start && start_rdy;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_t_d   = best_t_q;
    hit_d      = hit_q;
    err_d      = err_q;

    case (state_q)
      COLLECT: begin
        if (bus.i_valid) begin
          // strict less-than keeps the earlier index on ties
          if (bus.i_result && (bus.i_t < best_t_q)) begin
            best_t_d   = bus.i_t;
            best_idx_d = idx_q;
            hit_d      = 1'b1;
          end
          idx_d = idx_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == IDX_W'(1)) state_d = DONE;
        end
      end
      DONE:    if (bus.i_ready) state_d = IDLE;
      default: ;
    endcase

    if (start_acc) begin
      rem_d      = bus.i_num_tri;
      idx_d      = '0;
      best_t_d   = T_INIT;
      best_idx_d = '0;
      hit_d      = 1'b0;
      state_d    = (bus.i_num_tri == '0) ? DONE : COLLECT;
    end

    if ((bus.i_valid && (state_q != COLLECT)) || (bus.i_start && !start_rdy))
      err_d = 1'b1;
  end

  assign bus.o_start_ready = start_rdy;
  assign bus.o_valid       = (state_q == DONE);
  assign bus.o_hit         = hit_q;
  assign bus.o_t           = best_t_q;
  assign bus.o_tri_idx     = best_idx_q;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_closest_hit.sv
// Directed bench for closest_hit: nearest-hit selection, empty rays, ties,
// signed distances, backpressure with back-to-back start, errors and reset.
module tb_closest_hit;
  localparam int IDX_W = 16;

  logic i_clk = 1'b0;
  logic i_rstn;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 i_clk = ~i_clk;

  closest_hit_if #(.IDX_W(IDX_W)) bus ();
  closest_hit #(.IDX_W(IDX_W), .T_INIT(32'sh7FFFFFFF)) dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic start_ray(input int n);
    bus.i_start = 1'b1; bus.i_num_tri = IDX_W'(n);
    step();
    bus.i_start = 1'b0; bus.i_num_tri = '0;
  endtask

  task automatic send(input logic hit, input logic [31:0] t);
    bus.i_valid = 1'b1; bus.i_result = hit; bus.i_t = t;
    step();
    bus.i_valid = 1'b0; bus.i_result = 1'b0; bus.i_t = '0;
  endtask

  task automatic consume();
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; step(); step(); i_rstn = 1'b1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.o_valid); end
    n_cmp++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.o_err); end
    n_cmp++; if (bus.o_start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready got %b exp 1", bus.o_start_ready); end
  endtask

  task automatic test_basic();
    start_ray(4);
    send(1'b1, 32'h00030000);
    send(1'b0, 32'h00010000);
    send(1'b1, 32'h00018000);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", bus.o_valid); end
    send(1'b1, 32'h00020000);
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", bus.o_valid); end
    n_cmp++; if (bus.o_hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit got %b exp 1", bus.o_hit); end
    n_cmp++; if (bus.o_t !== 32'h00018000) begin n_fail++; $display("FAIL basic_t got %h exp 00018000", bus.o_t); end
    n_cmp++; if (bus.o_tri_idx !== 16'd2) begin n_fail++; $display("FAIL basic_idx got %0d exp 2", bus.o_tri_idx); end
    consume();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_after_consume got %b exp 0", bus.o_valid); end
  endtask

  task automatic test_nohit();
    start_ray(3);
    send(1'b0, 32'h00001000);
    send(1'b0, 32'h80000000);
    send(1'b0, 32'h00000001);
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL nohit_valid got %b exp 1", bus.o_valid); end
    n_cmp++; if (bus.o_hit !== 1'b0) begin n_fail++; $display("FAIL nohit_hit got %b exp 0", bus.o_hit); end
    n_cmp++; if (bus.o_t !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL nohit_t got %h exp 7fffffff", bus.o_t); end
    n_cmp++; if (bus.o_tri_idx !== 16'd0) begin n_fail++; $display("FAIL nohit_idx got %0d exp 0", bus.o_tri_idx); end
    consume();
  endtask

  task automatic test_zero();
    start_ray(0);
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid got %b exp 1", bus.o_valid); end
    n_cmp++; if (bus.o_hit !== 1'b0) begin n_fail++; $display("FAIL zero_hit got %b exp 0", bus.o_hit); end
    n_cmp++; if (bus.o_t !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL zero_t got %h exp 7fffffff", bus.o_t); end
    consume();
  endtask

  task automatic test_tie_neg();
    start_ray(2);
    send(1'b1, 32'h00008000);
    send(1'b1, 32'h00008000);
    n_cmp++; if (bus.o_tri_idx !== 16'd0) begin n_fail++; $display("FAIL tie_idx got %0d exp 0", bus.o_tri_idx); end
    n_cmp++; if (bus.o_t !== 32'h00008000) begin n_fail++; $display("FAIL tie_t got %h exp 00008000", bus.o_t); end
    consume();
    start_ray(2);
    send(1'b1, 32'hFFFF0000);
    send(1'b1, 32'h00010000);
    n_cmp++; if (bus.o_t !== 32'hFFFF0000) begin n_fail++; $display("FAIL neg_t got %h exp ffff0000", bus.o_t); end
    n_cmp++; if (bus.o_tri_idx !== 16'd0) begin n_fail++; $display("FAIL neg_idx got %0d exp 0", bus.o_tri_idx); end
    consume();
  endtask

  task automatic test_back_to_back();
    start_ray(1);
    send(1'b1, 32'h00050000);
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_t !== 32'h00050000 || bus.o_hit !== 1'b1)
        begin n_fail++; $display("FAIL hold_outputs cyc %0d got v=%b t=%h h=%b exp v=1 t=00050000 h=1", c, bus.o_valid, bus.o_t, bus.o_hit); end
      n_cmp++; if (bus.o_start_ready !== 1'b0) begin n_fail++; $display("FAIL hold_start_ready cyc %0d got %b exp 0", c, bus.o_start_ready); end
      step();
    end
    bus.i_ready = 1'b1; bus.i_start = 1'b1; bus.i_num_tri = 16'd1;
    #1;
    n_cmp++; if (bus.o_start_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_start_ready got %b exp 1", bus.o_start_ready); end
    step();
    bus.i_ready = 1'b0; bus.i_start = 1'b0; bus.i_num_tri = '0;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_collect_valid got %b exp 0", bus.o_valid); end
    send(1'b1, 32'h00007000);
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_t !== 32'h00007000 || bus.o_tri_idx !== 16'd0)
      begin n_fail++; $display("FAIL b2b_second got v=%b t=%h i=%0d exp v=1 t=00007000 i=0", bus.o_valid, bus.o_t, bus.o_tri_idx); end
    n_cmp++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b exp 0", bus.o_err); end
    consume();
  endtask

  task automatic test_errors();
    send(1'b1, 32'h00000100);
    n_cmp++; if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL err_idle_valid got %b exp 1", bus.o_err); end
    step(); step();
    n_cmp++; if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", bus.o_err); end
    start_ray(3);
    send(1'b1, 32'h00002000);
    i_rstn = 1'b0; step(); i_rstn = 1'b1;
    n_cmp++; if (bus.o_valid !== 1'b0 || bus.o_err !== 1'b0 || bus.o_start_ready !== 1'b1)
      begin n_fail++; $display("FAIL mid_reset got v=%b e=%b sr=%b exp v=0 e=0 sr=1", bus.o_valid, bus.o_err, bus.o_start_ready); end
    start_ray(2);
    start_ray(0);
    n_cmp++; if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL err_busy_start got %b exp 1", bus.o_err); end
    send(1'b1, 32'h00040000);
    send(1'b1, 32'h00003000);
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_t !== 32'h00003000 || bus.o_tri_idx !== 16'd1)
      begin n_fail++; $display("FAIL ignored_start_ray got v=%b t=%h i=%0d exp v=1 t=00003000 i=1", bus.o_valid, bus.o_t, bus.o_tri_idx); end
    consume();
  endtask

  initial begin
    i_rstn = 1'b0;
    bus.i_start = 1'b0; bus.i_num_tri = '0; bus.i_valid = 1'b0;
    bus.i_t = '0; bus.i_result = 1'b0; bus.i_ready = 1'b0;
    test_reset();
    test_basic();
    test_nohit();
    test_zero();
    test_tie_neg();
    test_back_to_back();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
